evo_circuit_test_sequencer: RTL and testbench

- Clocked controller that exercises an evolved asynchronous LCELL circuit (N-bit input, 1-bit output) for fitness evaluation.
- Steps through every input pattern. For each pattern it waits a settle period, then counts output toggles over a fixed measurement window.
- Streams one result per pattern to the fitness logic over a valid/ready handshake.
- Sits between the GA/fitness controller and the free-running evolved circuit under test.

---
 rtl/evo_circuit_test_sequencer.sv | 128 ++++++++++++
 tb/tb_evo_circuit_test_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evo_circuit_test_sequencer.sv
// Sweeps every input pattern of an evolved async circuit, lets it settle, then counts
// synchronized output toggles over a fixed window. Optional macro: HIGH_TIME_COUNT_EN (res_high).
module evo_circuit_test_sequencer #(
    parameter int IN_WIDTH      = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int WINDOW_CYCLES = 256,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [IN_WIDTH-1:0]  dut_in,
    input  logic                 dut_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [IN_WIDTH-1:0]  res_pattern,
    output logic [CNT_WIDTH-1:0] res_toggles,
`ifdef HIGH_TIME_COUNT_EN
    output logic [CNT_WIDTH-1:0] res_high,
`endif
    output logic                 res_level
);
    localparam int TMAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int CW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, REPORT} state_t;

    state_t               state, state_d;
    logic [1:0]           sync_ff;
    logic                 sync, prev;
    logic [CW-1:0]        cnt;
    logic [IN_WIDTH-1:0]  pattern;
    logic [CNT_WIDTH-1:0] toggles, tog_nxt;
    logic                 handshake, last_pat;
`ifdef HIGH_TIME_COUNT_EN
    logic [CNT_WIDTH-1:0] high, high_nxt;
`endif

    assign sync      = sync_ff[1];
    assign busy      = (state != IDLE);
    assign res_valid = (state == REPORT);
    assign dut_in    = pattern;
    assign handshake = res_valid && res_ready;
    assign last_pat  = &pattern;

    // The first window cycle only seeds prev; counts saturate instead of wrapping.
    assign tog_nxt = toggles + CNT_WIDTH'((cnt != '0) && (sync != prev) && (toggles != '1));
`ifdef HIGH_TIME_COUNT_EN
    assign high_nxt = high + CNT_WIDTH'(sync && (high != '1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_d = SETTLE;
                SETTLE:  if (cnt == CW'(SETTLE_CYCLES)) state_d = MEASURE;
                MEASURE: if (cnt == CW'(WINDOW_CYCLES - 1)) state_d = REPORT;
                REPORT:  if (handshake) state_d = last_pat ? IDLE : SETTLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff     <= '0;
            prev        <= 1'b0;
            cnt         <= '0;
            pattern     <= '0;
            toggles     <= '0;
            done        <= 1'b0;
            res_pattern <= '0;
            res_toggles <= '0;
            res_level   <= 1'b0;
`ifdef HIGH_TIME_COUNT_EN
            high        <= '0;
            res_high    <= '0;
`endif
        end else begin
            sync_ff <= {sync_ff[0], dut_out};
            done    <= 1'b0;
            if (state_d != state)
                cnt <= '0;
            else if (state == SETTLE || state == MEASURE)
                cnt <= cnt + 1'b1;
            case (state)
                SETTLE: begin
                    toggles <= '0;
`ifdef HIGH_TIME_COUNT_EN
                    high    <= '0;
`endif
                end
                MEASURE: begin
                    prev    <= sync;
                    toggles <= tog_nxt;
`ifdef HIGH_TIME_COUNT_EN
                    high    <= high_nxt;
`endif
                    if (state_d == REPORT) begin
                        res_pattern <= pattern;
                        res_toggles <= tog_nxt;
                        res_level   <= sync;
`ifdef HIGH_TIME_COUNT_EN
                        res_high    <= high_nxt;
`endif
                    end
                end
                REPORT: if (handshake && !abort && last_pat) done <= 1'b1;
                default: ;
            endcase
            if (state_d == IDLE)
                pattern <= '0;
            else if (state == REPORT && state_d == SETTLE)
                pattern <= pattern + 1'b1;
        end
    end
endmodule

// File: tb/tb_evo_circuit_test_sequencer.sv
// Randomized bench for evo_circuit_test_sequencer: per-pattern circuit behaviours
// (stuck low, stuck high, oscillator) checked against an arithmetic model of a sweep.
module tb_evo_circuit_test_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 0, abort = 0, res_ready = 1;
    logic        busy, done, res_valid, res_level;
    logic [1:0]  dut_in, res_pattern;
    logic [15:0] res_toggles, res_high;
    logic        dut_out = 0;

    logic        start1 = 0, abort1 = 0, ready1 = 1;
    logic        busy1, done1, valid1, lvl1;
    logic [1:0]  din1, pat1;
    logic [3:0]  tog1, high1;
    logic        dout1 = 0;

    int checks = 0, errors = 0;
    int cyc = 0, t0 = 0, done_n;
    int mode [4];
    int q_pat[$], q_tog[$], q_lvl[$], q_high[$], q_n[$], q_din[$];

    evo_circuit_test_sequencer u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
        .dut_in(dut_in), .dut_out(dut_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_pattern(res_pattern), .res_toggles(res_toggles),
`ifdef HIGH_TIME_COUNT_EN
        .res_high(res_high),
`endif
        .res_level(res_level));

    evo_circuit_test_sequencer #(.IN_WIDTH(2), .SETTLE_CYCLES(4), .WINDOW_CYCLES(32), .CNT_WIDTH(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .busy(busy1), .done(done1),
        .dut_in(din1), .dut_out(dout1), .res_valid(valid1), .res_ready(ready1),
        .res_pattern(pat1), .res_toggles(tog1),
`ifdef HIGH_TIME_COUNT_EN
        .res_high(high1),
`endif
        .res_level(lvl1));

`ifndef HIGH_TIME_COUNT_EN
    assign res_high = '0;
    assign high1    = '0;
`endif

    // Circuit models: mode 0 stuck low, 1 stuck high, 2 inverts every clock.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        case (mode[dut_in])
            0:       dut_out <= 1'b0;
            1:       dut_out <= 1'b1;
            default: dut_out <= ~dut_out;
        endcase
        dout1 <= ~dout1;
    end

    function automatic int sat(int v, int cw);
        int m = (1 << cw) - 1;
        return (v > m) ? m : v;
    endfunction
    function automatic int exp_tog(int m, int w, int cw);
        return sat((m == 2) ? w - 1 : 0, cw);
    endfunction
    function automatic int exp_high(int m, int w, int cw);
        return sat((m == 1) ? w : (m == 2) ? w / 2 : 0, cw);
    endfunction

    task automatic do_start();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0; t0 = cyc;
    endtask

    // Runs one sweep and records every accepted result; rmode 1 randomizes res_ready.
    task automatic collect(input int rmode);
        bit fin = 0;
        q_pat.delete(); q_tog.delete(); q_lvl.delete(); q_high.delete(); q_n.delete(); q_din.delete();
        done_n = -1;
        res_ready = 1;
        do_start();
        while (!fin && (cyc - t0) < 5000) begin
            @(negedge clk);
            res_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (res_valid && res_ready) begin
                q_pat.push_back(res_pattern); q_tog.push_back(res_toggles);
                q_lvl.push_back(res_level);   q_high.push_back(res_high);
                q_n.push_back(cyc - t0);      q_din.push_back(dut_in);
            end
            if (done) begin done_n = cyc - t0; fin = 1; end
        end
        res_ready = 1;
        if (!fin) begin
            checks++; errors++;
            $display("FAIL collect_timeout: no done within 5000 cycles");
        end
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if ({busy, done, res_valid, dut_in, res_pattern, res_toggles, res_level, res_high} !== '0) begin
            errors++; $display("FAIL reset_u0: busy=%b done=%b valid=%b din=%0d pat=%0d tog=%0d lvl=%b high=%0d, all required 0",
                busy, done, res_valid, dut_in, res_pattern, res_toggles, res_level, res_high);
        end
        checks++;
        if ({busy1, done1, valid1, din1, pat1, tog1, lvl1, high1} !== '0) begin
            errors++; $display("FAIL reset_u1: busy=%b done=%b valid=%b, all required 0", busy1, done1, valid1);
        end
        @(negedge clk); rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_stuck_low();
        mode = '{0, 0, 0, 0};
        collect(0);
        checks++;
        if (q_pat.size() != 4) begin errors++; $display("FAIL stuck_count: got %0d results, need 4", q_pat.size()); end
        for (int k = 0; k < q_pat.size() && k < 4; k++) begin
            checks++;
            if (q_pat[k] != k || q_tog[k] != 0 || q_lvl[k] != 0) begin
                errors++; $display("FAIL stuck_res%0d: pat=%0d tog=%0d lvl=%0d, need pat=%0d tog=0 lvl=0", k, q_pat[k], q_tog[k], q_lvl[k], k);
            end
            checks++;
            if (q_n[k] != 273 + 274 * k) begin
                errors++; $display("FAIL stuck_latency%0d: valid at %0d, need %0d", k, q_n[k], 273 + 274 * k);
            end
        end
        if (q_n.size() == 4) begin
            checks++;
            if (done_n != q_n[3] + 1) begin errors++; $display("FAIL stuck_done: done at %0d, need %0d", done_n, q_n[3] + 1); end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL stuck_idle: busy=%b done=%b, need 0 0", busy, done); end
    endtask

    task automatic test_oscillator();
        mode = '{1, 1, 2, 1};
        collect(0);
        for (int k = 0; k < q_pat.size(); k++) begin
            checks++;
            if (q_tog[k] != exp_tog(mode[k], 256, 16) || (mode[k] != 2 && q_lvl[k] != 1)) begin
                errors++; $display("FAIL osc_res%0d: tog=%0d lvl=%0d, need tog=%0d lvl=1", k, q_tog[k], q_lvl[k], exp_tog(mode[k], 256, 16));
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < 4; p++) mode[p] = $urandom_range(0, 2);
            collect(1);
            checks++;
            if (q_pat.size() != 4) begin errors++; $display("FAIL rand%0d_count: got %0d results, need 4", r, q_pat.size()); end
            for (int k = 0; k < q_pat.size(); k++) begin
                int m = mode[q_pat[k]];
                checks++;
                if (q_pat[k] != k || q_din[k] != k || q_tog[k] != exp_tog(m, 256, 16) || (m != 2 && q_lvl[k] != m)) begin
                    errors++; $display("FAIL rand%0d_res%0d: pat=%0d din=%0d tog=%0d lvl=%0d, need pat=%0d tog=%0d mode=%0d",
                        r, k, q_pat[k], q_din[k], q_tog[k], q_lvl[k], k, exp_tog(m, 256, 16), m);
                end
`ifdef HIGH_TIME_COUNT_EN
                checks++;
                if (q_high[k] != exp_high(m, 256, 16)) begin
                    errors++; $display("FAIL rand%0d_high%0d: high=%0d, need %0d", r, k, q_high[k], exp_high(m, 256, 16));
                end
`endif
            end
        end
    endtask

    task automatic test_backpressure();
        for (int p = 0; p < 4; p++) mode[p] = $urandom_range(0, 2);
        res_ready = 1;
        do_start();
        while (!(res_valid && res_pattern == 1) && (cyc - t0) < 2000) @(negedge clk);
        res_ready = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_pattern !== 2'd1 || dut_in !== 2'd1 || res_toggles !== 16'(exp_tog(mode[1], 256, 16))) begin
                errors++; $display("FAIL bp_hold%0d: valid=%b pat=%0d din=%0d tog=%0d, need 1 1 1 %0d",
                    i, res_valid, res_pattern, dut_in, res_toggles, exp_tog(mode[1], 256, 16));
            end
        end
        res_ready = 1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || dut_in !== 2'd2 || busy !== 1'b1) begin
            errors++; $display("FAIL bp_release: valid=%b din=%0d busy=%b, need 0 2 1", res_valid, dut_in, busy);
        end
        abort = 1; @(negedge clk); abort = 0;
    endtask

    task automatic test_abort();
        int seen = 0;
        mode = '{0, 2, 1, 0};
        res_ready = 1;
        do_start();
        while ((cyc - t0) < 700) @(negedge clk);
        checks++;
        if (dut_in !== 2'd2) begin errors++; $display("FAIL abort_pre: din=%0d, need 2", dut_in); end
        abort = 1; @(negedge clk); abort = 0;
        checks++;
        if (busy !== 1'b0 || dut_in !== 2'd0 || res_valid !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_post: busy=%b din=%0d valid=%b done=%b, need all 0", busy, dut_in, res_valid, done);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done || res_valid || busy) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL abort_quiet: %0d active cycles, need 0", seen); end
        start = 1; abort = 1; @(negedge clk); start = 0; abort = 0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_idle: busy=%b, need 0", busy); end
        // Abort coinciding with the final handshake must not produce done.
        do_start();
        while (!(res_valid && res_pattern == 3) && (cyc - t0) < 2000) @(negedge clk);
        abort = 1; @(negedge clk); abort = 0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("FAIL abort_handshake: done=%b busy=%b valid=%b, need 0 0 0", done, busy, res_valid);
        end
        mode = '{0, 0, 0, 0};
        collect(0);
        checks++;
        if (q_pat.size() != 4 || q_pat[0] != 0 || q_n[0] != 273) begin
            errors++; $display("FAIL abort_restart: results=%0d, need 4 starting at pattern 0 cycle 273", q_pat.size());
        end
    endtask

    task automatic test_reset_mid();
        mode = '{0, 1, 2, 1};
        res_ready = 1;
        do_start();
        while ((cyc - t0) < 830) @(negedge clk);
        checks++;
        if (dut_in !== 2'd3 || res_valid !== 1'b0) begin errors++; $display("FAIL rmid_pre: din=%0d valid=%b, need 3 0", dut_in, res_valid); end
        rst_n = 0; #1;
        checks++;
        if ({busy, done, res_valid, dut_in, res_pattern, res_toggles, res_level, res_high} !== '0) begin
            errors++; $display("FAIL rmid_async: busy=%b valid=%b din=%0d pat=%0d tog=%0d, all required 0",
                busy, res_valid, dut_in, res_pattern, res_toggles);
        end
        @(negedge clk); rst_n = 1;
        mode = '{0, 0, 0, 0};
        collect(0);
        checks++;
        if (q_pat.size() != 4 || q_pat[3] != 3 || done_n != q_n[q_n.size() - 1] + 1) begin
            errors++; $display("FAIL rmid_sweep: results=%0d done_n=%0d, need 4 results and done after last", q_pat.size(), done_n);
        end
    endtask

    task automatic test_saturation();
        int k = 0, n = 0;
        @(negedge clk); start1 = 1;
        @(negedge clk); start1 = 0;
        while (!done1 && n < 1000) begin
            @(negedge clk); n++;
            if (valid1 && ready1) begin
                checks++;
                if (pat1 != 2'(k) || tog1 != 4'(exp_tog(2, 32, 4)) || high1 != 4'(`ifdef HIGH_TIME_COUNT_EN exp_high(2, 32, 4) `else 0 `endif)) begin
                    errors++; $display("FAIL sat_res%0d: pat=%0d tog=%0d high=%0d, need pat=%0d tog=%0d", k, pat1, tog1, high1, k, exp_tog(2, 32, 4));
                end
                k++;
            end
        end
        checks++;
        if (k != 4 || !done1) begin errors++; $display("FAIL sat_count: %0d results done=%b, need 4 and done", k, done1); end
    endtask

    initial begin
        mode = '{0, 0, 0, 0};
        test_reset();
        test_stuck_low();
        test_oscillator();
        test_random();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
